// File: rtl/wires.sv
// Shared bus type definitions for the memory_valid/memory_ready bus.
// The arbiter side and the responder side both import these, so the bus is
// defined in exactly one place.
//   mem_req_type : initiator -> responder (valid, instr, addr, wdata, wstrb)
//   mem_rsp_type : responder -> initiator (rdata, ready)
package wires;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_type;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
  } mem_rsp_type;

endpackage

// File: rtl/sram_bank.sv
// Storage for memory_responder: DEPTH x 32 synchronous RAM with per-byte
// write enables and a registered read port. No decode or sequencing here.
//   clk, rst  : clock, synchronous active-high reset (read register only)
//   en_i      : access enable for this edge
//   we_i      : 1 = write, 0 = read (when en_i)
//   be_i      : byte enables for writes
//   addr_i    : word index
//   wdata_i   : write data
//   rdata_o   : registered read data, updated only on enabled reads
module sram_bank #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               rdata_q <= '0;
    else if (en_i && !we_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// On-chip memory target below the arbiter. Serves one request at a time out
// of a byte-writable RAM, with separate read/write wait states.
//   clk, rst      : clock, synchronous active-high reset
//   memory_valid  : request present, fields stable until memory_ready
//   memory_instr  : instruction fetch, always a read
//   memory_addr   : byte address, [1:0] ignored
//   memory_wdata  : write data
//   memory_wstrb  : byte enables, 0 = read
//   memory_rdata  : read data while memory_ready, else 0
//   memory_ready  : one-cycle completion pulse
module memory_responder
  import wires::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH      = 4096,
  parameter int          READ_WAIT  = 1,
  parameter int          WRITE_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] RWAIT  = 4'(READ_WAIT);
  localparam logic [3:0] WWAIT  = 4'(WRITE_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          we;
    logic          hit;
  } reg_t;

  reg_t        r_q, r_d;
  mem_req_type req;
  mem_rsp_type rsp;

  assign req = '{valid: memory_valid, instr: memory_instr, addr: memory_addr,
                 wdata: memory_wdata, wstrb: memory_wstrb};

  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = req.addr[1:0];

  // BASE_ADDR is window-aligned, so a hit is a match on the bits above the index.
  logic          req_hit, req_we;
  logic [AW-1:0] req_idx;
  logic [3:0]    req_wait;
  assign req_idx  = req.addr[AW+1:2];
  assign req_hit  = (req.addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign req_we   = (req.wstrb != 4'h0) && !req.instr;
  assign req_wait = req_we ? WWAIT : RWAIT;

  logic          ram_en, ram_we;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_wdata, ram_rdata;
  logic [3:0]    ram_be;

  always_comb begin
    r_d       = r_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_idx   = r_q.idx;
    ram_wdata = r_q.wdata;
    ram_be    = r_q.wstrb;
    unique case (r_q.state)
      IDLE: begin
        if (req.valid) begin
          r_d.idx   = req_idx;
          r_d.wdata = req.wdata;
          r_d.wstrb = req.wstrb;
          r_d.we    = req_we;
          r_d.hit   = req_hit;
          r_d.cnt   = req_wait;
          if (req_wait == 4'd0) begin
            // Zero-wait access: RAM driven straight from the bus this edge.
            ram_en    = req_hit;
            ram_we    = req_we;
            ram_idx   = req_idx;
            ram_wdata = req.wdata;
            ram_be    = req.wstrb;
            r_d.state = RESP;
          end else begin
            r_d.state = WAIT;
          end
        end
      end
      WAIT: begin
        r_d.cnt = r_q.cnt - 4'd1;
        if (r_q.cnt == 4'd1) begin
          ram_en    = r_q.hit;
          ram_we    = r_q.we;
          r_d.state = RESP;
        end
      end
      RESP:    r_d.state = IDLE;
      default: r_d.state = IDLE;
    endcase
    // A reset edge abandons the access; nothing may be committed on it.
    if (rst) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else     r_q <= r_d;
  end

  sram_bank #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk     (clk),
    .rst     (rst),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_idx),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // RAM read register is only meaningful for a read hit; misses and writes return 0.
  assign rsp.ready = (r_q.state == RESP);
  assign rsp.rdata = (rsp.ready && r_q.hit && !r_q.we) ? ram_rdata : 32'h0;

  assign memory_ready = rsp.ready;
  assign memory_rdata = rsp.rdata;

endmodule

// File: doc/memory_responder.md
# memory_responder

Single-port responder for the core's `memory_valid`/`memory_ready` bus. Serves requests from the arbiter out of an internal word-addressed, byte-writable RAM, with wait states set independently for reads and writes. One access is in flight at a time; no error channel exists on this bus. Sits directly below the arbiter as the on-chip memory target.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be 4·`DEPTH`-aligned.
- `DEPTH`, 4096: number of 32-bit words; power of two, 16..65536.
- `READ_WAIT`, 1: extra cycles before a read response; 0..15.
- `WRITE_WAIT`, 0: extra cycles before a write response; 0..15.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `memory_valid`  in  1  request present; held with stable fields until `memory_ready`.
- `memory_instr`  in  1  instruction fetch; forces a read.
- `memory_addr`  in  32  byte address; bits [1:0] are ignored.
- `memory_wdata`  in  32  write data.
- `memory_wstrb`  in  4  byte enables; 0 = read, nonzero = write.
- `memory_rdata`  out  32  read data; valid only while `memory_ready`=1, 0 otherwise.
- `memory_ready`  out  1  single-cycle completion pulse.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** when `memory_valid`=1 at an edge, accept the request.
  - Latch the word index, `wdata`, `wstrb`, the write flag (`wstrb`≠0 and `memory_instr`=0), and the hit flag.
  - Hit flag: `BASE_ADDR` ≤ addr < `BASE_ADDR`+4·`DEPTH`.
  - Load the counter with `READ_WAIT` or `WRITE_WAIT`.
  - Counter = 0: perform the access on this same edge and go to RESP. Otherwise go to WAIT.
- **WAIT:** decrement the counter each edge. On the edge where counter = 1, perform the access and go to RESP.
- **Perform access:**
  - Write hit: update only the bytes whose strobe is set.
  - Read hit: register the word into the rdata register.
  - Miss: writes are dropped; reads register 0.
- **RESP:** `memory_ready`=1 and `memory_rdata`=rdata register (0 for writes). Return to IDLE unconditionally.
  - Bus inputs during RESP are ignored. The initiator may already present its next request in that cycle; it is accepted from IDLE on the following edge.
- `memory_instr`=1 with nonzero `wstrb`: treated as a read, RAM unchanged.
- Read after write to the same word returns the new data; there is no bypass hazard because accesses are serialized.
- `memory_valid` dropping mid-request is a protocol violation. The responder still completes the latched access and pulses ready.

## Timing
- Reset (`rst`=1 at an edge): state=IDLE, counter=0, rdata register=0, `memory_ready`=0, `memory_rdata`=0.
  - An access in WAIT is abandoned and its write is not committed.
  - RAM contents are not cleared.
- Latency: request first valid in cycle 0 → `memory_ready`=1 in cycle 1+W, where W is the applicable wait count.
- Initiation interval: 2+W cycles per access (one idle-accept cycle after each RESP).
- `memory_ready` is a registered (state-decoded) output with no combinational path from any input. `memory_rdata` is registered.
- Word index = `memory_addr`[log2(DEPTH)+1:2]. Counter width is 4 bits.

## Structure
- Add `mem_req_type` (valid, instr, addr, wdata, wstrb) and `mem_rsp_type` (rdata, ready) to the shared `wires` package, so the arbiter-side and responder-side bus share one definition.
- FSM state enum and the r/rin register struct stay local to the module.
- One sub-module, `sram_bank`: synchronous DEPTH×32 array with a 4-bit byte write enable and a registered read port. It holds the storage only; the FSM, decode and counter live in `memory_responder`.

## Test plan
- Write `addr`=0x10, `wdata`=0xDEADBEEF, `wstrb`=4'hF, `WRITE_WAIT`=0 → ready in cycle 1. Then read 0x10 with `READ_WAIT`=1 → ready in cycle 2 with rdata=0xDEADBEEF.
- Byte strobe: word 0x20 holds 0x11223344; write `wdata`=0xAABBCCDD, `wstrb`=4'b0101 → read returns 0x11BB33DD.
- Back-to-back: `memory_valid` held high across two reads to 0x0 and 0x4, with the address switched in the ready cycle → second ready exactly 3 cycles after the first (`READ_WAIT`=1). Both rdata values correct.
- Out of range: `DEPTH`=4096, read 0x0000_4000 → ready after normal latency, rdata=0. A write there leaves word 0 unchanged.
- Instruction fetch with `wstrb`=4'hF, `memory_instr`=1 at 0x8 → treated as a read: returns the stored word, memory unchanged.
- Reset mid-operation: `WRITE_WAIT`=3, assert `rst` in the second WAIT cycle → ready never pulses, outputs 0 next cycle, and a later read of that address shows the old value.
